// File: rtl/psram_qspi_responder.sv
// psram_qspi_responder: device-side end of an SPI/QSPI/QPI PSRAM link.
// sck, ce_n and sio_i are oversampled with clk (clk >= 8x sck). Commands,
// addresses and write data are sampled on sck rises. Read data is driven
// on sck falls. A byte-wide synchronous memory port is used as backing store.
//
// Memory port contract: mem_addr is registered. mem_rdata must hold the byte
// at mem_addr one clk after mem_addr changes. mem_we is a single-clk strobe;
// mem_addr and mem_wdata are stable while it is high. mem_addr advances on
// the clk after the strobe.
module psram_qspi_responder #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ce_n,
  input  logic [3:0]        sio_i,
  output logic [3:0]        sio_o,
  output logic [3:0]        sio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              qpi_mode,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RD     = 3'd4,
    ST_WR     = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t state, state_nxt;

  logic              sck_s1, sck_s2;
  logic              ce_s1, ce_s2;
  logic [3:0]        sio_s1, sio_s2;
  logic              rise, fall;

  logic [4:0]        bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        cmd_sr;
  logic [ADDR_W-1:0] addr_sr;
  logic [7:0]        wr_sr;
  logic [7:0]        hold;
  logic              xfer_quad;
  logic              is_read;
  logic              fetch_s1, fetch_s2;

  logic [7:0]        cmd_next;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        wr_next;
  logic              cmd_last, addr_last, byte_last, wait_last;
  logic              dec_valid, dec_read, dec_quad, dec_set, dec_clr;

  assign rise      = sck_s1 & ~sck_s2;
  assign fall      = ~sck_s1 & sck_s2;
  assign state_dbg = state;

  // Two-flop synchronizers; ce_n resets to its inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      ce_s1  <= 1'b1;
      ce_s2  <= 1'b1;
      sio_s1 <= 4'h0;
      sio_s2 <= 4'h0;
    end else begin
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      ce_s1  <= ce_n;
      ce_s2  <= ce_s1;
      sio_s1 <= sio_i;
      sio_s2 <= sio_s1;
    end
  end

  // Shift-register next values, phase-end flags and command decode.
  always_comb begin
    cmd_next  = qpi_mode  ? ((cmd_sr << 4) | 8'(sio_s2))
                          : ((cmd_sr << 1) | 8'(sio_s2[0]));
    addr_next = xfer_quad ? ((addr_sr << 4) | ADDR_W'(sio_s2))
                          : ((addr_sr << 1) | ADDR_W'(sio_s2[0]));
    wr_next   = xfer_quad ? ((wr_sr << 4) | 8'(sio_s2))
                          : ((wr_sr << 1) | 8'(sio_s2[0]));
    cmd_last  = qpi_mode  ? (bit_cnt == 5'd1) : (bit_cnt == 5'd7);
    addr_last = xfer_quad ? (bit_cnt == 5'd5) : (bit_cnt == 5'd23);
    byte_last = xfer_quad ? (bit_cnt == 5'd1) : (bit_cnt == 5'd7);
    wait_last = (wait_cnt == WAIT_LAST);
    dec_valid = 1'b0;
    dec_read  = 1'b0;
    dec_quad  = 1'b0;
    dec_set   = 1'b0;
    dec_clr   = 1'b0;
    if (!qpi_mode) begin
      case (cmd_next)
        8'h03: begin dec_valid = 1'b1; dec_read = 1'b1; end
        8'h02: dec_valid = 1'b1;
        8'hEB: begin dec_valid = 1'b1; dec_read = 1'b1; dec_quad = 1'b1; end
        8'h38: begin dec_valid = 1'b1; dec_quad = 1'b1; end
        8'h35: dec_set = 1'b1;
        default: ;
      endcase
    end else begin
      case (cmd_next)
        8'hEB:        begin dec_valid = 1'b1; dec_read = 1'b1; dec_quad = 1'b1; end
        8'h02, 8'h38: begin dec_valid = 1'b1; dec_quad = 1'b1; end
        8'hF5:        dec_clr = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic; chip-enable high returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!ce_s2) state_nxt = ST_CMD;
      ST_CMD:  if (rise && cmd_last) state_nxt = dec_valid ? ST_ADDR : ST_IGNORE;
      ST_ADDR: if (rise && addr_last) begin
        if (!is_read)                            state_nxt = ST_WR;
        else if (xfer_quad && (WAIT_CYCLES != 0)) state_nxt = ST_WAIT;
        else                                     state_nxt = ST_RD;
      end
      ST_WAIT: if (rise && wait_last) state_nxt = ST_RD;
      default: ;
    endcase
    if (ce_s2) state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Datapath: shift registers, memory port, read prefetch and pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 5'd0;
      wait_cnt  <= '0;
      cmd_sr    <= 8'h00;
      addr_sr   <= '0;
      wr_sr     <= 8'h00;
      hold      <= 8'h00;
      xfer_quad <= 1'b0;
      is_read   <= 1'b0;
      fetch_s1  <= 1'b0;
      fetch_s2  <= 1'b0;
      qpi_mode  <= 1'b0;
      sio_o     <= 4'h0;
      sio_oe    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      fetch_s1 <= 1'b0;
      fetch_s2 <= fetch_s1;
      if (fetch_s2) hold <= mem_rdata;
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      case (state)
        ST_IDLE: begin
          bit_cnt  <= 5'd0;
          wait_cnt <= '0;
          sio_oe   <= 4'h0;
        end
        ST_CMD: if (rise) begin
          cmd_sr <= cmd_next;
          if (cmd_last) begin
            bit_cnt   <= 5'd0;
            is_read   <= dec_read;
            xfer_quad <= dec_quad;
            if (dec_set) qpi_mode <= 1'b1;
            if (dec_clr) qpi_mode <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ST_ADDR: if (rise) begin
          addr_sr <= addr_next;
          if (addr_last) begin
            bit_cnt  <= 5'd0;
            mem_addr <= addr_next;
            fetch_s1 <= is_read;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ST_WAIT: if (rise) wait_cnt <= wait_cnt + WAIT_W'(1);
        ST_RD: if (fall) begin
          if (xfer_quad) begin
            sio_o  <= bit_cnt[0] ? hold[3:0] : hold[7:4];
            sio_oe <= 4'b1111;
          end else begin
            sio_o  <= {2'b00, hold[3'd7 - bit_cnt[2:0]], 1'b0};
            sio_oe <= 4'b0010;
          end
          if (byte_last) begin
            bit_cnt  <= 5'd0;
            mem_addr <= mem_addr + ADDR_W'(1);
            fetch_s1 <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        // A byte completing in the same clk as ce_n going high is still written.
        ST_WR: if (rise) begin
          wr_sr <= wr_next;
          if (byte_last) begin
            bit_cnt   <= 5'd0;
            mem_wdata <= wr_next;
            mem_we    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: ;
      endcase
      if (ce_s2) sio_oe <= 4'h0;
    end
  end

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Directed bench for psram_qspi_responder: a controller model drives sck/ce_n/sio,
// byte memories back two instances (16-bit and 4-bit address) and a write
// log is checked against an expected queue.
module tb_psram_qspi_responder;

  logic        clk = 1'b0;
  logic        rst, sck, ce_n;
  logic [3:0]  sio_i;
  logic [3:0]  sio_o, sio_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, qpi_mode;
  logic [2:0]  state_dbg;

  logic [3:0]  sio_o4, sio_oe4;
  logic [3:0]  mem_addr4;
  logic [7:0]  mem_wdata4, mem_rdata4;
  logic        mem_we4, qpi_mode4;
  logic [2:0]  state_dbg4;

  logic [7:0]  mem16 [65536];
  logic [7:0]  mem4  [16];

  logic [23:0] exp_q[$];
  logic [23:0] wr_q[$];
  logic [11:0] exp4_q[$];
  logic [11:0] wr4_q[$];
  logic [3:0]  oe_acc;

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock and reset block.
  always #5 clk = ~clk;

  psram_qspi_responder #(.ADDR_W(16), .WAIT_CYCLES(6)) u_dut (
    .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n), .sio_i(sio_i),
    .sio_o(sio_o), .sio_oe(sio_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .qpi_mode(qpi_mode), .state_dbg(state_dbg)
  );

  psram_qspi_responder #(.ADDR_W(4), .WAIT_CYCLES(6)) u_dut4 (
    .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n), .sio_i(sio_i),
    .sio_o(sio_o4), .sio_oe(sio_oe4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_we(mem_we4), .mem_rdata(mem_rdata4), .qpi_mode(qpi_mode4), .state_dbg(state_dbg4)
  );

  // Synchronous byte memories with one-clk read latency, plus write logging.
  always @(posedge clk) begin
    if (mem_we) begin
      mem16[mem_addr] <= mem_wdata;
      wr_q.push_back({mem_addr, mem_wdata});
    end
    mem_rdata <= mem16[mem_addr];
    if (mem_we4) begin
      mem4[mem_addr4] <= mem_wdata4;
      wr4_q.push_back({mem_addr4, mem_wdata4});
    end
    mem_rdata4 <= mem4[mem_addr4];
  end

  // Driver tasks.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sck period: present data while sck is low, sample the responder just
  // before the rise, then hold sck high for half a period.
  task automatic sck_cycle(input logic [3:0] dout, output logic [3:0] din, output logic [3:0] oe);
    sio_i  = dout;
    tick(5);
    din    = sio_o;
    oe     = sio_oe;
    oe_acc = oe_acc | sio_oe;
    sck    = 1'b1;
    tick(5);
    sck    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic quad);
    logic [3:0] d, o;
    if (quad) begin
      sck_cycle(b[7:4], d, o);
      sck_cycle(b[3:0], d, o);
    end else begin
      for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, d, o);
    end
  endtask

  task automatic send_addr(input logic [23:0] a, input logic quad);
    send_byte(a[23:16], quad);
    send_byte(a[15:8], quad);
    send_byte(a[7:0], quad);
  endtask

  task automatic recv_byte(input logic quad, output logic [7:0] b,
                           output logic [3:0] oe_or, output logic [3:0] oe_and);
    logic [3:0] d, o;
    b      = 8'h00;
    oe_or  = 4'h0;
    oe_and = 4'hF;
    for (int i = 0; i < (quad ? 2 : 8); i++) begin
      sck_cycle(4'h0, d, o);
      b      = quad ? {b[3:0], d} : {b[6:0], d[1]};
      oe_or  = oe_or | o;
      oe_and = oe_and & o;
    end
  endtask

  task automatic frame_begin;
    ce_n = 1'b0;
    tick(5);
  endtask

  task automatic frame_end;
    ce_n = 1'b1;
    tick(10);
  endtask

  task automatic clear_logs;
    wr_q.delete();
    wr4_q.delete();
    exp_q.delete();
    exp4_q.delete();
  endtask

  // Tests.
  task automatic test_reset;
    rst = 1'b1; sck = 1'b0; ce_n = 1'b1; sio_i = 4'h0; oe_acc = 4'h0;
    tick(3);
    tests_run++;
    if ({sio_o, sio_oe, mem_we, qpi_mode} !== 10'h000) begin
      tests_failed++;
      $display("FAIL reset_pins: got sio_o=%h sio_oe=%h we=%b qpi=%b, expected all 0", sio_o, sio_oe, mem_we, qpi_mode);
    end
    tests_run++;
    if ({mem_addr, mem_wdata} !== 24'h000000) begin
      tests_failed++;
      $display("FAIL reset_mem: got addr=%h wdata=%h, expected 0000/00", mem_addr, mem_wdata);
    end
    tests_run++;
    if ({sio_o4, sio_oe4, mem_addr4, mem_we4, qpi_mode4} !== 14'h0000) begin
      tests_failed++;
      $display("FAIL reset_dut4: got sio_o=%h oe=%h addr=%h we=%b qpi=%b, expected 0", sio_o4, sio_oe4, mem_addr4, mem_we4, qpi_mode4);
    end
    rst = 1'b0;
    tick(5);
    tests_run++;
    if ({state_dbg, state_dbg4} !== 6'o00) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d/%0d, expected 0/0 (IDLE)", state_dbg, state_dbg4);
    end
  endtask

  task automatic test_spi_write_read;
    logic [7:0] b;
    logic [3:0] oo, oa;
    clear_logs();
    exp_q.push_back({16'h0010, 8'hA5});
    exp_q.push_back({16'h0011, 8'h3C});
    frame_begin();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000010, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    frame_end();
    tests_run++;
    if (wr_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL spi_wr_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      tests_run++;
      if (wr_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL spi_wr_%0d: got addr/data %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
    frame_begin();
    send_byte(8'h03, 1'b0);
    send_addr(24'h000010, 1'b0);
    recv_byte(1'b0, b, oo, oa);
    tests_run++;
    if ({b, oo, oa} !== {8'hA5, 4'b0010, 4'b0010}) begin
      tests_failed++;
      $display("FAIL spi_rd_0: got data=%h oe_or=%b oe_and=%b, expected A5 0010 0010", b, oo, oa);
    end
    recv_byte(1'b0, b, oo, oa);
    tests_run++;
    if ({b, oo, oa} !== {8'h3C, 4'b0010, 4'b0010}) begin
      tests_failed++;
      $display("FAIL spi_rd_1: got data=%h oe_or=%b oe_and=%b, expected 3C 0010 0010", b, oo, oa);
    end
    frame_end();
    tests_run++;
    if (sio_oe !== 4'h0) begin
      tests_failed++;
      $display("FAIL spi_rd_release: got sio_oe=%b after ce_n high, expected 0000", sio_oe);
    end
  endtask

  task automatic test_quad_read_dummy;
    logic [3:0] d, o;
    logic [3:0] exp_nib [4];
    int zero_cnt;
    exp_nib = '{4'h1, 4'h2, 4'h3, 4'h4};
    clear_logs();
    frame_begin();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000020, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    frame_end();
    tests_run++;
    if (wr_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL quad_preload: got %0d writes, expected 2", wr_q.size());
    end
    frame_begin();
    send_byte(8'hEB, 1'b0);
    send_addr(24'h000020, 1'b1);
    zero_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sck_cycle(4'h0, d, o);
      if (o == 4'h0) zero_cnt++;
    end
    tests_run++;
    if (zero_cnt !== 6) begin
      tests_failed++;
      $display("FAIL quad_dummy_oe: got %0d dummy cycles with oe=0, expected 6", zero_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      sck_cycle(4'h0, d, o);
      tests_run++;
      if ({o, d} !== {4'hF, exp_nib[i]}) begin
        tests_failed++;
        $display("FAIL quad_nib_%0d: got oe=%b nib=%h, expected 1111 %h", i, o, d, exp_nib[i]);
      end
    end
    frame_end();
  endtask

  task automatic test_qpi_entry_exit;
    logic [7:0] b;
    logic [3:0] oo, oa;
    clear_logs();
    frame_begin();
    send_byte(8'h35, 1'b0);
    frame_end();
    tests_run++;
    if ({qpi_mode, qpi_mode4} !== 2'b11) begin
      tests_failed++;
      $display("FAIL qpi_enter: got qpi_mode=%b/%b, expected 1/1", qpi_mode, qpi_mode4);
    end
    exp_q.push_back({16'h0000, 8'hEF});
    frame_begin();
    send_byte(8'h38, 1'b1);
    send_addr(24'h000000, 1'b1);
    send_byte(8'hEF, 1'b1);
    frame_end();
    tests_run++;
    if (wr_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL qpi_wr_count: got %0d writes, expected 1", wr_q.size());
    end else begin
      tests_run++;
      if (wr_q[0] !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL qpi_wr: got addr/data %h, expected %h", wr_q[0], exp_q[0]);
      end
    end
    frame_begin();
    send_byte(8'hF5, 1'b1);
    frame_end();
    tests_run++;
    if ({qpi_mode, qpi_mode4} !== 2'b00) begin
      tests_failed++;
      $display("FAIL qpi_exit: got qpi_mode=%b/%b, expected 0/0", qpi_mode, qpi_mode4);
    end
    frame_begin();
    send_byte(8'h03, 1'b0);
    send_addr(24'h000000, 1'b0);
    recv_byte(1'b0, b, oo, oa);
    frame_end();
    tests_run++;
    if ({b, oa} !== {8'hEF, 4'b0010}) begin
      tests_failed++;
      $display("FAIL qpi_readback: got data=%h oe=%b, expected EF 0010", b, oa);
    end
  endtask

  task automatic test_wrap;
    clear_logs();
    exp4_q.push_back({4'hF, 8'h11});
    exp4_q.push_back({4'h0, 8'h22});
    exp4_q.push_back({4'h1, 8'h33});
    exp_q.push_back({16'h000F, 8'h11});
    exp_q.push_back({16'h0010, 8'h22});
    exp_q.push_back({16'h0011, 8'h33});
    frame_begin();
    send_byte(8'h02, 1'b0);
    send_addr(24'h00000F, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    frame_end();
    tests_run++;
    if (wr4_q.size() !== 3) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d writes, expected 3", wr4_q.size());
    end
    for (int i = 0; i < exp4_q.size() && i < wr4_q.size(); i++) begin
      tests_run++;
      if (wr4_q[i] !== exp4_q[i]) begin
        tests_failed++;
        $display("FAIL wrap_wr_%0d: got addr/data %h, expected %h", i, wr4_q[i], exp4_q[i]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      tests_run++;
      if (wr_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL wide_wr_%0d: got addr/data %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_unknown_and_partial;
    logic [3:0] d, o;
    clear_logs();
    oe_acc = 4'h0;
    frame_begin();
    send_byte(8'h9F, 1'b0);
    for (int i = 0; i < 16; i++) sck_cycle(4'hF, d, o);
    tests_run++;
    if (state_dbg !== 3'd6) begin
      tests_failed++;
      $display("FAIL unknown_state: got %0d, expected 6 (IGNORE)", state_dbg);
    end
    frame_end();
    tests_run++;
    if (oe_acc !== 4'h0 || wr_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL unknown_cmd: got oe_seen=%b writes=%0d, expected 0000 and 0", oe_acc, wr_q.size());
    end
    frame_begin();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000040, 1'b0);
    send_byte(8'h5A, 1'b0);
    sck_cycle(4'h1, d, o);
    sck_cycle(4'h0, d, o);
    sck_cycle(4'h1, d, o);
    sck_cycle(4'h0, d, o);
    frame_end();
    tests_run++;
    if (wr_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL partial_count: got %0d writes, expected 1", wr_q.size());
    end else begin
      tests_run++;
      if (wr_q[0] !== {16'h0040, 8'h5A}) begin
        tests_failed++;
        $display("FAIL partial_wr: got addr/data %h, expected 00405a", wr_q[0]);
      end
    end
    wr_q.delete();
    frame_begin();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000050, 1'b0);
    send_byte(8'h77, 1'b0);
    frame_end();
    tests_run++;
    if (wr_q.size() !== 1 || wr_q[0] !== {16'h0050, 8'h77}) begin
      tests_failed++;
      $display("FAIL after_partial: got %0d writes first=%h, expected 1 write 005077", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'h0);
    end
  endtask

  task automatic test_reset_mid_read;
    logic [3:0] d, o;
    logic [7:0] b;
    logic [3:0] oo, oa;
    frame_begin();
    send_byte(8'h35, 1'b0);
    frame_end();
    frame_begin();
    send_byte(8'hEB, 1'b1);
    send_addr(24'h000020, 1'b1);
    for (int i = 0; i < 6; i++) sck_cycle(4'h0, d, o);
    sck_cycle(4'h0, d, o);
    tests_run++;
    if ({o, d} !== 8'hF1) begin
      tests_failed++;
      $display("FAIL midrd_first: got oe=%b nib=%h, expected 1111 1", o, d);
    end
    tick(4);
    rst = 1'b1;
    tick(1);
    tests_run++;
    if ({sio_oe, qpi_mode, state_dbg} !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrd_reset: got oe=%b qpi=%b state=%0d, expected 0000 0 0", sio_oe, qpi_mode, state_dbg);
    end
    rst  = 1'b0;
    ce_n = 1'b1;
    tick(10);
    frame_begin();
    send_byte(8'h03, 1'b0);
    send_addr(24'h000020, 1'b0);
    recv_byte(1'b0, b, oo, oa);
    frame_end();
    tests_run++;
    if ({b, oo, oa} !== {8'h12, 4'b0010, 4'b0010}) begin
      tests_failed++;
      $display("FAIL midrd_next_frame: got data=%h oe_or=%b oe_and=%b, expected 12 0010 0010", b, oo, oa);
    end
  endtask

  initial begin
    test_reset();
    test_spi_write_read();
    test_quad_read_dummy();
    test_qpi_entry_exit();
    test_wrap();
    test_unknown_and_partial();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
